// File: rtl/spell_pkg.sv
// Shared spell-engine definitions: memory-type codes and the memory arbiter state encoding.
package spell_pkg;

  localparam logic [1:0] MEM_CODE = 2'b00;
  localparam logic [1:0] MEM_DATA = 2'b01;
  localparam logic [1:0] MEM_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_CORE = 2'd1,
    ST_GRANT_HOST = 2'd2,
    ST_DRAIN      = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_HOST = 1'b1
  } requester_t;

endpackage

// File: rtl/spell_mem_arbiter.sv
// Two-requester (spell core / Wishbone host) round-robin arbiter in front of spell_mem_dff,
// with per-access timeout and a one-cycle drain when a requester abandons its access.
module spell_mem_arbiter
  import spell_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       core_select,
  input  logic       core_write,
  input  logic [7:0] core_addr,
  input  logic [7:0] core_data_in,
  input  logic [1:0] core_type,
  output logic [7:0] core_data_out,
  output logic       core_ready,

  input  logic       host_select,
  input  logic       host_write,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_data_in,
  input  logic [1:0] host_type,
  output logic [7:0] host_data_out,
  output logic       host_ready,

  output logic       mem_select,
  output logic       mem_write,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic [1:0] mem_type,
  input  logic [7:0] mem_data_out,
  input  logic       mem_ready,

  output logic       timeout_err
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  arb_state_t state_reg, state_next;
  requester_t last_served_reg, last_served_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_err_reg, timeout_err_next;
  logic [7:0] core_data_reg;
  logic [7:0] host_data_reg;

  logic grant_core;
  logic grant_host;
  logic granted_select;
  logic complete;

  assign grant_core     = (state_reg == ST_GRANT_CORE);
  assign grant_host     = (state_reg == ST_GRANT_HOST);
  assign granted_select = grant_host ? host_select : core_select;
  // A completion only counts while the owner still holds its select; otherwise it is draining.
  assign complete       = (grant_core | grant_host) & granted_select & mem_ready;

  always_comb begin
    state_next       = state_reg;
    last_served_next = last_served_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (core_select && (!host_select || last_served_reg == REQ_HOST)) begin
          state_next       = ST_GRANT_CORE;
          last_served_next = REQ_CORE;
          wait_cnt_next    = '0;
        end else if (host_select) begin
          state_next       = ST_GRANT_HOST;
          last_served_next = REQ_HOST;
          wait_cnt_next    = '0;
        end
      end
      ST_GRANT_CORE, ST_GRANT_HOST: begin
        if (!granted_select) begin
          state_next = ST_DRAIN;
        end else if (mem_ready) begin
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_next == TIMEOUT_LIMIT) begin
            state_next       = ST_IDLE;
            timeout_err_next = 1'b1;
          end
        end
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      last_served_reg <= REQ_HOST;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
      core_data_reg   <= '0;
      host_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      last_served_reg <= last_served_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
      if (complete && grant_core) core_data_reg <= mem_data_out;
      if (complete && grant_host) host_data_reg <= mem_data_out;
    end
  end

  // Read data is passed through in the completion cycle and held from the register afterwards.
  assign core_ready    = complete & grant_core;
  assign host_ready    = complete & grant_host;
  assign core_data_out = core_ready ? mem_data_out : core_data_reg;
  assign host_data_out = host_ready ? mem_data_out : host_data_reg;

  assign mem_select  = grant_core | grant_host;
  assign mem_write   = (grant_core & core_write) | (grant_host & host_write);
  assign mem_addr    = grant_host ? host_addr    : (grant_core ? core_addr    : 8'h00);
  assign mem_data_in = grant_host ? host_data_in : (grant_core ? core_data_in : 8'h00);
  assign mem_type    = grant_host ? host_type    : (grant_core ? core_type    : MEM_NONE);

  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Self-checking bench for spell_mem_arbiter: directed scenarios followed by randomized
// request traffic, checked against a transaction-level round-robin/timeout model.
module tb_spell_mem_arbiter;
  import spell_pkg::*;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       core_select, core_write;
  logic [7:0] core_addr, core_data_in, core_data_out;
  logic [1:0] core_type;
  logic       core_ready;
  logic       host_select, host_write;
  logic [7:0] host_addr, host_data_in, host_data_out;
  logic [1:0] host_type;
  logic       host_ready;
  logic       mem_select, mem_write;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;
  logic [1:0] mem_type;
  logic       mem_ready;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: who was served last (1 = host) and each requester's held read data.
  int         last_host;
  logic [7:0] exp_core_data;
  logic [7:0] exp_host_data;

  always #5 clock = ~clock;

  spell_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .core_select(core_select), .core_write(core_write), .core_addr(core_addr),
    .core_data_in(core_data_in), .core_type(core_type),
    .core_data_out(core_data_out), .core_ready(core_ready),
    .host_select(host_select), .host_write(host_write), .host_addr(host_addr),
    .host_data_in(host_data_in), .host_type(host_type),
    .host_data_out(host_data_out), .host_ready(host_ready),
    .mem_select(mem_select), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_type(mem_type),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic rdy(input int who);
    return (who == 0) ? core_ready : host_ready;
  endfunction

  function automatic logic [7:0] dout(input int who);
    return (who == 0) ? core_data_out : host_data_out;
  endfunction

  task automatic new_req(input int who);
    logic [1:0] t;
    case ($urandom_range(0, 2))
      0:       t = MEM_CODE;
      1:       t = MEM_DATA;
      default: t = MEM_NONE;
    endcase
    if (who == 0) begin
      core_select = 1'b1; core_write = 1'($urandom_range(0, 1));
      core_addr = 8'($urandom); core_data_in = 8'($urandom); core_type = t;
    end else begin
      host_select = 1'b1; host_write = 1'($urandom_range(0, 1));
      host_addr = 8'($urandom); host_data_in = 8'($urandom); host_type = t;
    end
  endtask

  task automatic drop(input int who);
    if (who == 0) core_select = 1'b0;
    else          host_select = 1'b0;
  endtask

  // Round-robin rule: a lone requester wins; with both, the one not served last wins.
  task automatic arbitrate(output int w);
    if (core_select && host_select) w = (last_host != 0) ? 0 : 1;
    else                            w = core_select ? 0 : 1;
    last_host = w;
  endtask

  task automatic check_fields(input int who);
    if (who == 0) begin
      chk("core_addr_fwd", mem_addr, core_addr);
      chk("core_wdata_fwd", mem_data_in, core_data_in);
      chk("core_type_fwd", mem_type, core_type);
      chk("core_write_fwd", mem_write, core_write);
    end else begin
      chk("host_addr_fwd", mem_addr, host_addr);
      chk("host_wdata_fwd", mem_data_in, host_data_in);
      chk("host_type_fwd", mem_type, host_type);
      chk("host_write_fwd", mem_write, host_write);
    end
  endtask

  // Called in an IDLE cycle where 'who' wins; returns in the IDLE cycle after the access ends.
  // lat = grant cycle on which memory answers (0 = never), abandon_k = grant cycle in which
  // the requester drops select (0 = never).
  task automatic do_access(input int who, input int lat, input int abandon_k,
                           input bit late_ready, input logic [7:0] rdata);
    logic [7:0] held;
    for (int k = 1; k <= T; k++) begin
      cycle();
      chk("grant_select", mem_select, 1);
      if (k == 1) check_fields(who);
      if (k == abandon_k) begin
        held = (who == 0) ? exp_core_data : exp_host_data;
        drop(who);
        #1;
        chk("abandon_ready", {core_ready, host_ready}, 0);
        cycle();
        mem_ready = late_ready; mem_data_out = rdata;
        #1;
        chk("drain_select", mem_select, 0);
        chk("drain_ready", {core_ready, host_ready}, 0);
        chk("drain_hold", dout(who), held);
        cycle();
        mem_ready = 1'b0;
        #1;
        chk("post_drain_select", mem_select, 0);
        chk("post_drain_hold", dout(who), held);
        return;
      end
      if (k == lat) begin
        mem_ready = 1'b1; mem_data_out = rdata;
        #1;
        chk("done_ready", rdy(who), 1);
        chk("done_other_ready", rdy(1 - who), 0);
        chk("done_data", dout(who), rdata);
        if (who == 0) exp_core_data = rdata;
        else          exp_host_data = rdata;
        cycle();
        mem_ready = 1'b0; mem_data_out = 8'($urandom);
        #1;
        chk("post_done_select", mem_select, 0);
        chk("post_done_ready", {core_ready, host_ready}, 0);
        chk("post_done_hold", dout(who), (who == 0) ? exp_core_data : exp_host_data);
        chk("post_done_timeout", timeout_err, 0);
        return;
      end
      #1;
      chk("wait_ready", {core_ready, host_ready}, 0);
      chk("wait_timeout", timeout_err, 0);
    end
    cycle();
    #1;
    chk("timeout_pulse", timeout_err, 1);
    chk("timeout_select", mem_select, 0);
    chk("timeout_ready", {core_ready, host_ready}, 0);
  endtask

  task automatic idle_step();
    cycle();
    mem_ready = 1'($urandom_range(0, 1)); mem_data_out = 8'($urandom);
    #1;
    chk("idle_select", mem_select, 0);
    chk("idle_write", mem_write, 0);
    chk("idle_ready", {core_ready, host_ready}, 0);
    chk("idle_timeout", timeout_err, 0);
    chk("idle_core_hold", core_data_out, exp_core_data);
    chk("idle_host_hold", host_data_out, exp_host_data);
    mem_ready = 1'b0;
  endtask

  initial begin
    int w;
    int lat;
    int ab;

    reset = 1'b1; mem_ready = 1'b0; mem_data_out = 8'h00;
    core_select = 1'b0; core_write = 1'b0; core_addr = 8'h00; core_data_in = 8'h00; core_type = MEM_NONE;
    host_select = 1'b0; host_write = 1'b0; host_addr = 8'h00; host_data_in = 8'h00; host_type = MEM_NONE;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    last_host = 1; exp_core_data = 8'h00; exp_host_data = 8'h00;
    chk("rst_select", mem_select, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_ready", {core_ready, host_ready}, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_core_data", core_data_out, 0);
    chk("rst_host_data", host_data_out, 0);

    // Core-only read of 0x10 (Code) answered on the 3rd grant cycle.
    core_select = 1'b1; core_write = 1'b0; core_addr = 8'h10; core_data_in = 8'h00; core_type = MEM_CODE;
    arbitrate(w);
    do_access(w, 3, 0, 1'b0, 8'h5A);
    drop(0);
    idle_step();

    // Simultaneous requests: core first, host two cycles after core completion.
    new_req(0); new_req(1);
    arbitrate(w);
    do_access(w, 2, 0, 1'b0, 8'($urandom));
    drop(w);
    arbitrate(w);
    do_access(w, 1, 0, 1'b0, 8'($urandom));
    drop(w);
    idle_step();

    // Both held high across four transactions: strict alternation.
    new_req(0); new_req(1);
    for (int i = 0; i < 4; i++) begin
      arbitrate(w);
      do_access(w, $urandom_range(1, T), 0, 1'b0, 8'($urandom));
      new_req(w);
    end
    drop(0); drop(1);
    idle_step();

    // Timeout with memory never ready, then a timed-out holder loses to the waiting requester.
    new_req(0);
    arbitrate(w);
    do_access(w, 0, 0, 1'b0, 8'h00);
    new_req(1);
    arbitrate(w);
    do_access(w, 0, 0, 1'b0, 8'h00);
    arbitrate(w);
    do_access(w, 2, 0, 1'b0, 8'($urandom));
    drop(0); drop(1);
    idle_step();

    // Host abandons in its 2nd grant cycle; memory answers one cycle later.
    new_req(1);
    arbitrate(w);
    do_access(w, 0, 2, 1'b1, 8'($urandom));
    idle_step();

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      if (!core_select && !host_select) begin
        idle_step();
        case ($urandom_range(0, 3))
          0: ;
          1: new_req(0);
          2: new_req(1);
          default: begin new_req(0); new_req(1); end
        endcase
      end else begin
        arbitrate(w);
        lat = $urandom_range(0, T + 1);
        ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, T) : 0;
        do_access(w, lat, ab, 1'($urandom_range(0, 1)), 8'($urandom));
        if ($urandom_range(0, 1) == 1) new_req(w);
        else                           drop(w);
        if (((w == 0) ? host_select : core_select) == 1'b0 && $urandom_range(0, 2) == 0)
          new_req(1 - w);
      end
    end
    drop(0); drop(1);
    idle_step();

    // Reset in the middle of a core access.
    new_req(0);
    arbitrate(w);
    cycle();
    chk("pre_reset_grant", mem_select, 1);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mem_ready = 1'b1; mem_data_out = 8'hA5;
    last_host = 1; exp_core_data = 8'h00; exp_host_data = 8'h00;
    #1;
    chk("reset_abort_select", mem_select, 0);
    chk("reset_abort_ready", core_ready, 0);
    chk("reset_core_data", core_data_out, 0);
    mem_ready = 1'b0;
    new_req(1);
    arbitrate(w);
    do_access(w, 1, 0, 1'b0, 8'($urandom));
    drop(0); drop(1);
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
